// File: rtl/fwd_scoreboard_if.sv
// Decode-stage bundle for the forwarding/scoreboard block: regfile operands,
// bypass sources and the resolved operands/stall going back to the pipeline.
interface fwd_scoreboard_if #(
    parameter int NREAD = 2,
    parameter int NSRC  = 2,
    parameter int DW    = 32,
    parameter int LATW  = 4,
    parameter int PCW   = 32
);
    logic                  id_valid;
    logic [NREAD*5-1:0]    id_rs;
    logic [NREAD*DW-1:0]   id_rdata;
    logic                  id_wen;
    logic [4:0]            id_rd;
    logic [LATW-1:0]       id_lat;
    logic [NSRC-1:0]       src_wen;
    logic [NSRC*5-1:0]     src_rd;
    logic [NSRC*DW-1:0]    src_data;
    logic [NSRC-1:0]       src_ready;
    logic                  flush;
    logic [NREAD*DW-1:0]   op_data;
    logic                  stall;
    logic                  issue_fire;
    logic [PCW-1:0]        stall_cycles;

    // Flow control: an instruction moves from decode into ID/EX exactly when
    // issue_fire is high (id_valid && !stall && !flush); otherwise it is held.
    modport master (
        output id_valid, id_rs, id_rdata, id_wen, id_rd, id_lat,
        output src_wen, src_rd, src_data, src_ready, flush,
        input  op_data, stall, issue_fire, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rdata, id_wen, id_rd, id_lat,
        input  src_wen, src_rd, src_data, src_ready, flush,
        output op_data, stall, issue_fire, stall_cycles
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding with prioritised bypass sources, a per-register countdown
// scoreboard for multi-cycle producers, a single stall and a stall counter.
module fwd_scoreboard #(
    parameter int NREAD = 2,
    parameter int NSRC  = 2,
    parameter int DW    = 32,
    parameter int LATW  = 4,
    parameter int PCW   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_scoreboard_if.slave   bus
);

    logic [LATW-1:0]     r_cnt [32];
    logic [PCW-1:0]      r_stall_cycles;

    logic [NREAD*DW-1:0] w_op_data;
    logic                w_lu_hazard;
    logic                w_raw_hazard;
    logic                w_waw_hazard;
    logic                w_stall;
    logic                w_issue_fire;
    logic                w_track;

    // The first matching source decides both the value and readiness, so a
    // ready lower-priority source can never mask a pending younger one.
    always_comb begin : fwd_resolve
        logic [4:0] rs;
        logic       hit;
        w_op_data    = '0;
        w_lu_hazard  = 1'b0;
        w_raw_hazard = 1'b0;
        rs           = '0;
        hit          = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rs  = bus.id_rs[5*i +: 5];
            hit = 1'b0;
            w_op_data[DW*i +: DW] = bus.id_rdata[DW*i +: DW];
            if (rs == 5'd0) begin
                w_op_data[DW*i +: DW] = '0;
            end else begin
                if (r_cnt[rs] != '0)
                    w_raw_hazard = 1'b1;
                for (int s = 0; s < NSRC; s++) begin
                    if (!hit && bus.src_wen[s] && (bus.src_rd[5*s +: 5] != 5'd0) &&
                        (bus.src_rd[5*s +: 5] == rs)) begin
                        hit = 1'b1;
                        if (bus.src_ready[s])
                            w_op_data[DW*i +: DW] = bus.src_data[DW*s +: DW];
                        else
                            w_lu_hazard = 1'b1;
                    end
                end
            end
        end
    end

    // A pending producer finishing no later than the new one is harmless.
    assign w_waw_hazard = bus.id_wen && (bus.id_rd != 5'd0) && (r_cnt[bus.id_rd] > bus.id_lat);
    assign w_stall      = bus.id_valid && (w_lu_hazard || w_raw_hazard || w_waw_hazard);
    assign w_issue_fire = bus.id_valid && !w_stall && !bus.flush;
    assign w_track      = w_issue_fire && bus.id_wen && (bus.id_rd != 5'd0) && (bus.id_lat != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                r_cnt[i] <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < 32; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_track && (bus.id_rd == 5'(i)))
                    r_cnt[i] <= bus.id_lat;
                else if (r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - LATW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != {PCW{1'b1}}))
            r_stall_cycles <= r_stall_cycles + PCW'(1);
    end

    assign bus.op_data      = w_op_data;
    assign bus.stall        = w_stall;
    assign bus.issue_fire   = w_issue_fire;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a 32-bit-counter instance plus a 4-bit
// counter twin fed the same stimulus to observe saturation.
module tb_fwd_scoreboard;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   exp_sc;

    fwd_scoreboard_if #(.PCW(32)) dif ();
    fwd_scoreboard_if #(.PCW(4))  sif ();

    fwd_scoreboard #(.PCW(32)) u_dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));
    fwd_scoreboard #(.PCW(4))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

    assign sif.id_valid  = dif.id_valid;
    assign sif.id_rs     = dif.id_rs;
    assign sif.id_rdata  = dif.id_rdata;
    assign sif.id_wen    = dif.id_wen;
    assign sif.id_rd     = dif.id_rd;
    assign sif.id_lat    = dif.id_lat;
    assign sif.src_wen   = dif.src_wen;
    assign sif.src_rd    = dif.src_rd;
    assign sif.src_data  = dif.src_data;
    assign sif.src_ready = dif.src_ready;
    assign sif.flush     = dif.flush;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dif.id_valid  = 1'b0;
        dif.id_rs     = '0;
        dif.id_rdata  = '0;
        dif.id_wen    = 1'b0;
        dif.id_rd     = '0;
        dif.id_lat    = '0;
        dif.src_wen   = '0;
        dif.src_rd    = '0;
        dif.src_data  = '0;
        dif.src_ready = '0;
        dif.flush     = 1'b0;
    endtask

    task automatic set_src(input int s, input logic wen, input logic [4:0] rd,
                           input logic [31:0] data, input logic rdy);
        dif.src_wen[s]         = wen;
        dif.src_rd[5*s +: 5]   = rd;
        dif.src_data[32*s +: 32] = data;
        dif.src_ready[s]       = rdy;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                          input logic wen, input logic [4:0] rd, input logic [3:0] lat);
        dif.id_valid = v;
        dif.id_rs    = {rs1, rs0};
        dif.id_wen   = wen;
        dif.id_rd    = rd;
        dif.id_lat   = lat;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_sc   = 0;
        rst_n    = 1'b0;
        idle();
        #3;
        check("reset_stall", 64'(dif.stall), 64'd0);
        check("reset_sc", 64'(dif.stall_cycles), 64'd0);
        check("reset_op", 64'(dif.op_data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // forwarding priority
        dif.id_rdata = {32'h2222, 32'h1111};
        set_src(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
        set_src(1, 1'b1, 5'd5, 32'hBBBB, 1'b1);
        set_id(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 4'd0);
        #1;
        check("prio_op0", 64'(dif.op_data[31:0]), 64'hAAAA);
        check("prio_op1_rf", 64'(dif.op_data[63:32]), 64'h2222);
        check("prio_stall", 64'(dif.stall), 64'd0);
        check("prio_fire", 64'(dif.issue_fire), 64'd1);
        dif.src_wen[0] = 1'b0;
        dif.id_rs = {5'd5, 5'd5};
        #1;
        check("src1_op0", 64'(dif.op_data[31:0]), 64'hBBBB);
        check("src1_op1_same", 64'(dif.op_data[63:32]), 64'hBBBB);
        idle();
        tick();

        // load-use: younger not-ready source must win over older ready one
        set_src(0, 1'b1, 5'd7, 32'h0, 1'b0);
        set_src(1, 1'b1, 5'd7, 32'h7777, 1'b1);
        set_id(1'b1, 5'd1, 5'd7, 1'b0, 5'd0, 4'd0);
        #1;
        check("lu_stall", 64'(dif.stall), 64'd1);
        check("lu_fire", 64'(dif.issue_fire), 64'd0);
        for (int k = 0; k < 3; k++) tick();
        exp_sc += 3;
        check("lu_sc", 64'(dif.stall_cycles), 64'(exp_sc));
        set_src(0, 1'b1, 5'd7, 32'h1234, 1'b1);
        #1;
        check("lu_op1", 64'(dif.op_data[63:32]), 64'h1234);
        check("lu_release", 64'(dif.stall), 64'd0);
        idle();
        tick();

        // multi-cycle RAW, lat=4
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 4'd4);
        #1;
        check("raw_issue_fire", 64'(dif.issue_fire), 64'd1);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("raw_stall_%0d", k), 64'(dif.stall), 64'd1);
            if (k == 1) begin
                dif.id_rs[4:0] = 5'd10;
                #1;
                check("raw_other_reg", 64'(dif.stall), 64'd0);
                dif.id_rs[4:0] = 5'd9;
            end
            tick();
        end
        exp_sc += 4;
        check("raw_release", 64'(dif.stall), 64'd0);
        check("raw_sc", 64'(dif.stall_cycles), 64'(exp_sc));
        idle();
        tick();

        // WAW: cnt[3]=5, new rd=3 lat=2 waits until cnt[3]<=2
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 4'd5);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 4'd2);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("waw_stall_%0d", k), 64'(dif.stall), 64'd1);
            tick();
        end
        exp_sc += 3;
        check("waw_release", 64'(dif.stall), 64'd0);
        check("waw_fire", 64'(dif.issue_fire), 64'd1);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 4'd0);
        #1;
        check("waw_reload_a", 64'(dif.stall), 64'd1);
        tick();
        check("waw_reload_b", 64'(dif.stall), 64'd1);
        tick();
        exp_sc += 2;
        check("waw_reload_done", 64'(dif.stall), 64'd0);
        idle();
        tick();

        // maximum latency 15
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 4'd15);
        tick();
        set_id(1'b1, 5'd12, 5'd0, 1'b0, 5'd0, 4'd0);
        for (int k = 0; k < 15; k++) begin
            #1;
            if (k == 0 || k == 14)
                check($sformatf("lat15_stall_%0d", k), 64'(dif.stall), 64'd1);
            tick();
        end
        exp_sc += 15;
        check("lat15_release", 64'(dif.stall), 64'd0);
        idle();
        tick();

        // r0 never forwards or stalls
        dif.id_rdata = {32'h0, 32'h5555};
        set_src(0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 4'd0);
        #1;
        check("r0_op0", 64'(dif.op_data[31:0]), 64'd0);
        check("r0_stall", 64'(dif.stall), 64'd0);
        idle();
        tick();

        // flush clears the scoreboard; it does not mask stall but blocks issue
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd20, 4'd6);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd21, 4'd6);
        tick();
        set_id(1'b1, 5'd20, 5'd21, 1'b0, 5'd0, 4'd0);
        dif.flush = 1'b1;
        #1;
        check("flush_stall_kept", 64'(dif.stall), 64'd1);
        check("flush_no_fire", 64'(dif.issue_fire), 64'd0);
        tick();
        exp_sc += 1;
        dif.flush = 1'b0;
        #1;
        check("flush_cleared", 64'(dif.stall), 64'd0);
        check("flush_fire", 64'(dif.issue_fire), 64'd1);
        idle();
        tick();

        // asynchronous reset mid-countdown
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 4'd8);
        tick();
        set_id(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 4'd0);
        #1;
        check("ar_pre_stall", 64'(dif.stall), 64'd1);
        check("ar_pre_sc", 64'(dif.stall_cycles), 64'(exp_sc));
        check("ar_pre_sat", 64'(sif.stall_cycles), 64'((exp_sc > 15) ? 15 : exp_sc));
        #2;
        rst_n = 1'b0;
        #1;
        exp_sc = 0;
        check("ar_stall", 64'(dif.stall), 64'd0);
        check("ar_sc", 64'(dif.stall_cycles), 64'd0);
        check("ar_sat", 64'(sif.stall_cycles), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_cnt_cleared", 64'(dif.stall), 64'd0);
        idle();
        tick();

        // saturation of the 4-bit counter
        set_src(0, 1'b1, 5'd7, 32'h0, 1'b0);
        set_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 4'd0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_sc++;
            if (k == 15 || k == 16 || k == 20) begin
                check($sformatf("sat_main_%0d", k), 64'(dif.stall_cycles), 64'(exp_sc));
                check($sformatf("sat_4b_%0d", k), 64'(sif.stall_cycles), 64'd15);
            end
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the ID/EX operand forwarding unit.
- Resolves NREAD source operands against NSRC prioritised bypass sources, including not-yet-ready sources such as loads in MEM.
- Adds a per-register scoreboard of countdown counters for multi-cycle producers (mul/div), and generates a single pipeline stall.
- Keeps a saturating stall-cycle performance counter. Sits in the decode stage between the regfile read and the ID/EX register.

Parameters:
- NREAD, 2, number of operand read ports.
- NSRC, 2, number of bypass sources; index 0 = youngest (EX/MEM), highest priority.
- DW, 32, datapath width.
- LATW, 4, width of the multi-cycle latency field and of each scoreboard counter.
- PCW, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a valid instruction.
- id_rs  in  NREAD*5  source register numbers; port i at bits [5i+4:5i].
- id_rdata  in  NREAD*DW  regfile read values.
- id_wen  in  1  decoded instruction writes a register.
- id_rd  in  5  decoded destination register.
- id_lat  in  LATW  multi-cycle latency; 0 = ordinary single-cycle/load op, not tracked.
- src_wen  in  NSRC  source s will write a register.
- src_rd  in  NSRC*5  destination register of each source.
- src_data  in  NSRC*DW  value of each source.
- src_ready  in  NSRC  src_data is valid this cycle; 0 for a load still in MEM.
- flush  in  1  pipeline flush (branch/exception).
- op_data  out  NREAD*DW  forwarded operands.
- stall  out  1  hold PC and IF/ID, bubble ID/EX.
- issue_fire  out  1  id_valid && !stall && !flush.
- stall_cycles  out  PCW  saturating count of stalled cycles.

Behaviour:
Forwarding (combinational):
- Per port i, source s matches when src_wen[s] && src_rd[s]!=0 && src_rd[s]==rs_i.
- The lowest matching s wins.
- If the winner has src_ready=1, op_data_i = src_data[s]. If no source matches, op_data_i = id_rdata_i.
- rs_i==0 always yields 0, never forwards and never stalls.
- A lower-priority ready match never overrides a higher-priority not-ready match.

Stall sources (combinational, all gated by id_valid; stall=0 when id_valid=0):
- (a) Load-use: the winning match for any port has src_ready=0.
- (b) RAW on multi-cycle: cnt[rs_i]!=0 for any port with rs_i!=0. The bypass sources are ignored here.
- (c) WAW: id_wen && id_rd!=0 && cnt[id_rd] > id_lat.
- flush does not suppress stall, but issue_fire is 0 while flush=1.

Scoreboard (sequential, cnt[1..31], each LATW bits; cnt[0] is constant 0):
- Each cycle, every nonzero cnt decrements by 1.
- On issue_fire && id_wen && id_rd!=0 && id_lat!=0: cnt[id_rd] <= id_lat. Issue wins over a same-cycle decrement of that entry.
- A counter reaching 0 means the result is now visible to the bypass/regfile path. The producer pipeline guarantees this timing.
- flush: all cnt <= 0 on the next edge. This takes precedence over issue, which cannot fire anyway.
- rst_n low: all cnt = 0 immediately (asynchronous); stall_cycles = 0. Outputs follow combinationally, so with id_valid=0, stall=0.

Perf counter:
- stall_cycles increments on each clk edge where stall=1.
- It saturates at all-ones and does not wrap. flush does not clear it.

Boundaries:
- Reset asserted mid-countdown clears all counters; the stall drops on the same cycle rs_n falls.
- id_lat = 2^LATW-1 is legal.
- The same register on multiple read ports is resolved independently with identical results.
- NSRC sources with equal rd are resolved by priority only.

Test Plan:
- Forward priority: src0 rd=5 data=0xAAAA ready, src1 rd=5 data=0xBBBB ready, rs0=5 -> op_data0=0xAAAA, stall=0. Drop src0_wen -> 0xBBBB.
- Load-use: src0 rd=7 ready=0, src1 rd=7 ready=1, rs1=7 -> stall=1, issue_fire=0, stall_cycles +1 per cycle. Raise src0 ready with data 0x1234 -> op_data1=0x1234, stall=0.
- Multi-cycle RAW: issue rd=9 lat=4, next instruction rs0=9 -> stall for exactly 4 cycles after the issue edge, then releases. Instruction with rs=10 during the countdown -> no stall.
- WAW: cnt[3]=5, new instruction wen rd=3 lat=2 -> stall until cnt[3]<=2. Then fire sets cnt[3]=2.
- r0 and flush: rs0=0 with src0 rd=0 wen -> op_data0=0, no stall. Counters set to 6, flush pulsed -> all cnt 0 next cycle, pending RAW stall clears.
- Async reset: rst_n low mid-countdown between edges -> stall=0 and stall_cycles=0 immediately. Preload stall_cycles near saturation (PCW=4, 15 stalls) -> stays at 15.
